// File: rtl/cic_decim_sequencer.sv
// cic_decim_sequencer: single-clock enable sequencer for a shared CIC decimator datapath,
// with warm-up discard, valid/ready output handshake, overrun flag and sample counter.
module cic_decim_sequencer #(
  parameter int STAGES  = 2,
  parameter int RATIO_W = 4,
  parameter int IDX_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [RATIO_W-1:0] ratio_cfg,
  input  logic               clr_ovr,
  output logic               dp_clr,
  output logic               integ_en,
  output logic               comb_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overrun,
  output logic               settled,
  output logic [IDX_W-1:0]   sample_idx
);
  localparam int WC_W = $clog2(STAGES + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WARMUP, RUN, DRAIN} state_t;

  state_t             state, state_n;
  logic [RATIO_W-1:0] phase, r_eff;
  logic [WC_W-1:0]    wcnt;
  logic               active, strobe, sample, accept, valid_n;

  assign active   = state == WARMUP || state == RUN;
  assign strobe   = active && phase == r_eff - RATIO_W'(1);
  assign sample   = state == RUN && strobe;
  assign accept   = out_valid && out_ready;
  assign valid_n  = sample || (out_valid && !out_ready);
  assign dp_clr   = state == CLEAR;
  assign integ_en = active;
  assign comb_en  = strobe;
  assign settled  = state == RUN;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:        state_n = en ? CLEAR : IDLE;
      CLEAR:       state_n = en ? WARMUP : IDLE;
      WARMUP, RUN: state_n = !en ? (valid_n ? DRAIN : IDLE)
                           : (state == WARMUP && strobe && wcnt == WC_W'(STAGES - 1)) ? RUN : state;
      DRAIN:       state_n = valid_n ? DRAIN : IDLE;
      default:     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r_eff      <= '0;
      phase      <= '0;
      wcnt       <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      sample_idx <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && en) r_eff <= (ratio_cfg < RATIO_W'(2)) ? RATIO_W'(2) : ratio_cfg;
      if (state == CLEAR) begin
        phase      <= '0;
        wcnt       <= '0;
        out_valid  <= 1'b0;
        overrun    <= 1'b0;
        sample_idx <= '0;
      end else begin
        if (active) phase <= strobe ? '0 : phase + RATIO_W'(1);
        if (state == WARMUP && strobe) wcnt <= wcnt + WC_W'(1);
        out_valid <= valid_n;
        if (accept) sample_idx <= sample_idx + IDX_W'(1);
        // a fresh overwrite beats a simultaneous clear request
        if (sample && out_valid && !out_ready) overrun <= 1'b1;
        else if (clr_ovr) overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cic_decim_sequencer.sv
// tb_cic_decim_sequencer: directed self-checking bench for cic_decim_sequencer
// (STAGES=2, RATIO_W=4, IDX_W=8).
module tb_cic_decim_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, en, clr_ovr, out_ready;
  logic [3:0] ratio_cfg;
  logic       dp_clr, integ_en, comb_en, out_valid, overrun, settled;
  logic [7:0] sample_idx;
  int         ncmp = 0;
  int         nfail = 0;
  int         p;

  cic_decim_sequencer #(.STAGES(2), .RATIO_W(4), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ratio_cfg(ratio_cfg), .clr_ovr(clr_ovr),
    .dp_clr(dp_clr), .integ_en(integ_en), .comb_en(comb_en), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .settled(settled), .sample_idx(sample_idx)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe;
    int n = 0;
    while (comb_en !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk("strobe_timeout", comb_en, 1);
  endtask

  task automatic period(output int pr);
    wait_strobe;
    pr = 0;
    do begin
      tick;
      pr++;
    end while (comb_en !== 1'b1 && pr < 40);
  endtask

  task automatic restart(input logic [3:0] r);
    en = 1'b0;
    tick; tick; tick;
    ratio_cfg = r;
    en = 1'b1;
    tick;
    chk("restart_clr", dp_clr, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; ratio_cfg = 4'd4; clr_ovr = 1'b0; out_ready = 1'b1;
    tick; tick;
    chk("rst_dp_clr", dp_clr, 0);
    chk("rst_integ", integ_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", sample_idx, 0);
    rst_n = 1'b1;
    tick;
    // basic sequencing with R=4, edge 0 is the next posedge
    en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick;
      chk("t1_dp_clr", dp_clr, c == 1);
      chk("t1_integ", integ_en, c >= 2);
      chk("t1_comb", comb_en, c == 5 || c == 9 || c == 13 || c == 17);
      chk("t1_valid", out_valid, c == 14 || c == 18);
      chk("t1_settled", settled, c >= 10);
      chk("t1_overrun", overrun, 0);
      if (c == 15) chk("t1_idx1", sample_idx, 1);
    end
    tick;
    chk("t1_idx2", sample_idx, 2);
    // hold one sample, then accept exactly on the next strobe
    out_ready = 1'b0;
    wait_strobe;
    tick;
    chk("t4_valid_pre", out_valid, 1);
    wait_strobe;
    out_ready = 1'b1;
    tick;
    chk("t4_valid", out_valid, 1);
    chk("t4_overrun", overrun, 0);
    chk("t4_idx", sample_idx, 3);
    out_ready = 1'b0;
    // overrun set, set-vs-clear priority, then plain clear
    wait_strobe;
    tick;
    chk("t3_overrun_set", overrun, 1);
    chk("t3_valid", out_valid, 1);
    wait_strobe;
    clr_ovr = 1'b1;
    tick;
    chk("t3_set_wins", overrun, 1);
    tick;
    chk("t3_clr", overrun, 0);
    clr_ovr = 1'b0;
    // drain with pending sample, en pulse ignored, then restart
    en = 1'b0;
    tick;
    chk("t5_integ", integ_en, 0);
    chk("t5_comb", comb_en, 0);
    chk("t5_valid", out_valid, 1);
    chk("t5_settled", settled, 0);
    en = 1'b1;
    tick;
    chk("t5_ign_clr", dp_clr, 0);
    chk("t5_ign_integ", integ_en, 0);
    chk("t5_ign_valid", out_valid, 1);
    en = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("t5_idle_valid", out_valid, 0);
    chk("t5_idle_idx", sample_idx, 4);
    chk("t5_idle_clr", dp_clr, 0);
    en = 1'b1;
    tick;
    chk("t5_restart_clr", dp_clr, 1);
    tick;
    chk("t5_restart_clr_off", dp_clr, 0);
    chk("t5_restart_idx", sample_idx, 0);
    chk("t5_restart_integ", integ_en, 1);
    // ratio mapping and latching
    restart(4'd0);
    period(p);
    chk("t2_r0", p, 2);
    restart(4'd1);
    period(p);
    chk("t2_r1", p, 2);
    restart(4'd15);
    period(p);
    chk("t2_r15", p, 15);
    ratio_cfg = 4'd3;
    period(p);
    period(p);
    chk("t2_run_settled", settled, 1);
    chk("t2_latched", p, 15);
    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_integ", integ_en, 0);
    chk("t6_settled", settled, 0);
    chk("t6_comb", comb_en, 0);
    chk("t6_clr", dp_clr, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_ovr", overrun, 0);
    chk("t6_idx", sample_idx, 0);
    tick;
    rst_n = 1'b1;
    ratio_cfg = 4'd0;
    en = 1'b1;
    // sample counter wrap
    for (int n = 0; n < 2000 && sample_idx !== 8'd255; n++) tick;
    chk("t6_idx255", sample_idx, 255);
    for (int n = 0; n < 20 && out_valid !== 1'b1; n++) tick;
    tick;
    chk("t6_wrap", sample_idx, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
